seg_counter_display: RTL and testbench

//  Parametrised successor of the single-digit bar controller: a prescaled up/down
//  hex counter with load, driving seven 24-bit colour bars as one 7-segment digit.

---
 rtl/seg_counter_display.sv | 186 ++++++++++++++++++
 tb/tb_seg_counter_display.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_counter_display.sv
// seg_counter_display: prescaled up/down hex counter with load and wrap pulse,
// rendered as one 7-segment digit on seven 24-bit colour bars (a..g = bar_0..bar_6).
// Optional feature macro: SEG_BLINK_EN adds a blink input and a tick-driven blink phase.
// Handshake note: there is no valid/ready channel here; load is a single-cycle
// strobe that is always accepted on the clock edge where it is high.
module seg_counter_display #(
  parameter int          CLK_DIV   = 16,
  parameter int          MAX_VAL   = 15,
  parameter logic [23:0] ON_COLOR  = 24'hFF0000,
  parameter logic [23:0] OFF_COLOR = 24'h000000,
  parameter int          BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        dir,
  input  logic        load,
  input  logic [3:0]  load_val,
`ifdef SEG_BLINK_EN
  input  logic        blink,
`endif
  output logic [3:0]  count,
  output logic        wrap,
  output logic [23:0] bar_0,
  output logic [23:0] bar_1,
  output logic [23:0] bar_2,
  output logic [23:0] bar_3,
  output logic [23:0] bar_4,
  output logic [23:0] bar_5,
  output logic [23:0] bar_6
);

  // Reject parameter sets the counter cannot represent.
  generate
    if (CLK_DIV < 1 || MAX_VAL < 1 || MAX_VAL > 15 || BLINK_DIV < 1) begin : g_bad_params
      $error("seg_counter_display: illegal CLK_DIV/MAX_VAL/BLINK_DIV");
    end
  endgenerate

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]    MAX4       = 4'(MAX_VAL);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [23:0]   bar_q [7];
  logic [23:0]   bar_d [7];
  logic [6:0]    seg;

  // Hex digit to segment pattern, bit order gfedcba.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // Prescaler and counter next state; load overrides a coincident tick.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MAX4) ? MAX4 : load_val;
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (!dir) begin
          if (count_q == MAX4) begin
            count_d = 4'd0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + 4'd1;
          end
        end else begin
          if (count_q == 4'd0) begin
            count_d = MAX4;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Prescaler, counter and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic          tick;
  logic          phase_q, phase_d;
  logic [BW-1:0] bl_cnt_q, bl_cnt_d;

  // Blink phase flips every BLINK_DIV count steps; cleared while blink is off.
  always_comb begin
    tick     = !load && en && (presc_q == PRESC_LAST);
    phase_d  = phase_q;
    bl_cnt_d = bl_cnt_q;
    if (!blink) begin
      phase_d  = 1'b0;
      bl_cnt_d = '0;
    end else if (tick) begin
      if (bl_cnt_q == BLINK_LAST) begin
        bl_cnt_d = '0;
        phase_d  = !phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= 1'b0;
      bl_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      bl_cnt_q <= bl_cnt_d;
    end
  end
`endif

  // Segment colours for the current count, blanked during the blink off-phase.
  always_comb begin
    seg = seg_decode(count_q);
    for (int i = 0; i < 7; i++) begin
      bar_d[i] = seg[i] ? ON_COLOR : OFF_COLOR;
`ifdef SEG_BLINK_EN
      if (blink && phase_q) bar_d[i] = OFF_COLOR;
`endif
    end
  end

  // Bar registers: one clock behind count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) bar_q[i] <= OFF_COLOR;
    end else begin
      for (int i = 0; i < 7; i++) bar_q[i] <= bar_d[i];
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign bar_0 = bar_q[0];
  assign bar_1 = bar_q[1];
  assign bar_2 = bar_q[2];
  assign bar_3 = bar_q[3];
  assign bar_4 = bar_q[4];
  assign bar_5 = bar_q[5];
  assign bar_6 = bar_q[6];

endmodule

// File: tb/tb_seg_counter_display.sv
// Bench for seg_counter_display: two instances (A: CLK_DIV=4 MAX_VAL=9,
// B: CLK_DIV=1 MAX_VAL=15) share one stimulus stream and are checked every
// cycle against a behavioural model, plus a directed vector table and sweeps.
module tb_seg_counter_display;

  localparam logic [23:0] ON_C  = 24'hFF0000;
  localparam logic [23:0] OFF_C = 24'h000000;
  localparam int          BDIV  = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst, en, dir, load;
  logic [3:0] load_val;
`ifdef SEG_BLINK_EN
  logic blink;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [3:0]  count_a, count_b;
  logic        wrap_a, wrap_b;
  logic [23:0] bars_a [7];
  logic [23:0] bars_b [7];

  seg_counter_display #(.CLK_DIV(4), .MAX_VAL(9), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .BLINK_DIV(BDIV)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .count(count_a), .wrap(wrap_a),
    .bar_0(bars_a[0]), .bar_1(bars_a[1]), .bar_2(bars_a[2]), .bar_3(bars_a[3]),
    .bar_4(bars_a[4]), .bar_5(bars_a[5]), .bar_6(bars_a[6])
  );

  seg_counter_display #(.CLK_DIV(1), .MAX_VAL(15), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .BLINK_DIV(BDIV)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .count(count_b), .wrap(wrap_b),
    .bar_0(bars_b[0]), .bar_1(bars_b[1]), .bar_2(bars_b[2]), .bar_3(bars_b[3]),
    .bar_4(bars_b[4]), .bar_5(bars_b[5]), .bar_6(bars_b[6])
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;

  int p_div [2] = '{4, 1};
  int p_max [2] = '{9, 15};

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int m_cnt [2], m_presc [2], m_wrap [2], m_digit [2], m_off [2];
  int m_phase [2], m_btick [2];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_wrap[i] = 0; m_digit[i] = 0;
      m_off[i] = 1; m_phase[i] = 0; m_btick[i] = 0;
    end
  endtask

  // One rising edge of the model using the inputs currently driven.
  task automatic model_edge();
    int prev, tick;
    for (int i = 0; i < 2; i++) begin
      prev = m_cnt[i];
      tick = 0;
      m_wrap[i] = 0;
      if (load) begin
        m_cnt[i]   = (int'(load_val) > p_max[i]) ? p_max[i] : int'(load_val);
        m_presc[i] = 0;
      end else if (en) begin
        if (m_presc[i] == p_div[i] - 1) begin
          tick = 1;
          m_presc[i] = 0;
          if (!dir) begin
            m_cnt[i]  = (m_cnt[i] + 1) % (p_max[i] + 1);
            m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
          end else begin
            m_cnt[i]  = (m_cnt[i] + p_max[i]) % (p_max[i] + 1);
            m_wrap[i] = (m_cnt[i] == p_max[i]) ? 1 : 0;
          end
        end else begin
          m_presc[i]++;
        end
      end
      m_digit[i] = prev;
`ifdef SEG_BLINK_EN
      m_off[i] = (blink && m_phase[i] == 1) ? 1 : 0;
      if (!blink) begin
        m_phase[i] = 0; m_btick[i] = 0;
      end else if (tick == 1) begin
        m_btick[i]++;
        if (m_btick[i] == BDIV) begin
          m_btick[i] = 0;
          m_phase[i] = 1 - m_phase[i];
        end
      end
`else
      m_off[i] = 0;
`endif
    end
  endtask

  function automatic logic [23:0] exp_bar(input int i, input int s);
    logic [6:0] pat;
    pat = seg_tbl[m_digit[i]];
    if (m_off[i] == 1) return OFF_C;
    return pat[s] ? ON_C : OFF_C;
  endfunction

  task automatic check_model();
    chk("count_a", 0, 32'(count_a), 32'(m_cnt[0]));
    chk("count_b", 1, 32'(count_b), 32'(m_cnt[1]));
    chk("wrap_a", 0, 32'(wrap_a), 32'(m_wrap[0]));
    chk("wrap_b", 1, 32'(wrap_b), 32'(m_wrap[1]));
    for (int s = 0; s < 7; s++) begin
      chk("bar_a", s, 32'(bars_a[s]), 32'(exp_bar(0, s)));
      chk("bar_b", s, 32'(bars_b[s]), 32'(exp_bar(1, s)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic chk_digit(input string name, input int d);
    logic [6:0] pat;
    pat = seg_tbl[d];
    for (int s = 0; s < 7; s++) chk(name, s, 32'(bars_b[s]), 32'(pat[s] ? ON_C : OFF_C));
  endtask

  typedef struct {
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] lv;
    int         cyc;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       wa;
    logic       wb;
  } vec_t;

  function automatic vec_t mk(input int e, input int d, input int l, input int lv, input int c,
                              input int ea, input int eb, input int wa, input int wb);
    vec_t v;
    v.en = e[0]; v.dir = d[0]; v.load = l[0]; v.lv = lv[3:0]; v.cyc = c;
    v.ea = ea[3:0]; v.eb = eb[3:0]; v.wa = wa[0]; v.wb = wb[0];
    return v;
  endfunction

  vec_t vecs [17];

  // ---------------- test sequence ----------------
  initial begin
    //            en dir ld lv cyc  A  B wA wB
    vecs[0]  = mk(1, 0, 0, 0, 4,   1, 4, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 32,  9, 4, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 2,   9, 6, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 20,  9, 6, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 1,   9, 7, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 1,   0, 8, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0, 4,   9, 4, 1, 0);
    vecs[7]  = mk(1, 1, 0, 0, 8,   7, 12, 0, 0);
    vecs[8]  = mk(1, 1, 1, 12, 1,  9, 12, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 3,   9, 15, 0, 0);
    vecs[10] = mk(1, 0, 1, 12, 1,  9, 12, 0, 0);
    vecs[11] = mk(0, 0, 1, 3, 1,   3, 3, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 4,   4, 7, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 2,   4, 9, 0, 0);
    vecs[14] = mk(1, 1, 0, 0, 2,   3, 7, 0, 0);
    vecs[15] = mk(1, 1, 1, 15, 1,  9, 15, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 1,   9, 0, 0, 1);

    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
`ifdef SEG_BLINK_EN
    blink = 1'b0;
`endif
    model_reset();
    #1;
    check_model();
    repeat (3) cycle();

    // Release reset; first edge shows digit 0 on the bars.
    rst = 1'b0;
    cycle();
    chk_digit("rst_digit0_b", 0);
    chk("rst_bar_a6", 6, 32'(bars_a[6]), 32'(OFF_C));
    chk("rst_bar_a0", 0, 32'(bars_a[0]), 32'(ON_C));

    // Directed vector table.
    for (int k = 0; k < 17; k++) begin
      en = vecs[k].en; dir = vecs[k].dir; load = vecs[k].load; load_val = vecs[k].lv;
      for (int c = 0; c < vecs[k].cyc; c++) cycle();
      chk("vec_count_a", k, 32'(count_a), 32'(vecs[k].ea));
      chk("vec_count_b", k, 32'(count_b), 32'(vecs[k].eb));
      chk("vec_wrap_a", k, 32'(wrap_a), 32'(vecs[k].wa));
      chk("vec_wrap_b", k, 32'(wrap_b), 32'(vecs[k].wb));
    end
    load = 1'b0;

    // Randomized run against the model.
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      load = ($urandom_range(0, 39) == 0);
      load_val = 4'($urandom_range(0, 15));
`ifdef SEG_BLINK_EN
      if ($urandom_range(0, 59) == 0) blink = ~blink;
`endif
      cycle();
    end
    load = 1'b0;
`ifdef SEG_BLINK_EN
    blink = 1'b0;
`endif

    // Reset asserted between edges mid-period: outputs clear at once.
    en = 1'b1; dir = 1'b0;
    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_count_a", 0, 32'(count_a), 32'd0);
    chk("midrst_count_b", 1, 32'(count_b), 32'd0);
    chk("midrst_wrap_b", 1, 32'(wrap_b), 32'd0);
    chk("midrst_bar_b0", 0, 32'(bars_b[0]), 32'(OFF_C));
    check_model();
    repeat (2) cycle();
    rst = 1'b0; en = 1'b0;
    cycle();
    chk_digit("midrst_digit0_b", 0);

    // Decode sweep through every hex value via load (en=0).
    for (int v = 0; v < 16; v++) begin
      load = 1'b1; load_val = 4'(v);
      cycle();
      load = 1'b0;
      cycle();
      chk("sweep_count_b", v, 32'(count_b), 32'(v));
      chk("sweep_count_a", v, 32'(count_a), 32'((v > 9) ? 9 : v));
      chk_digit("sweep_bar_b", v);
    end

`ifdef SEG_BLINK_EN
    // Blink with BLINK_DIV=2 on the every-cycle instance: bars alternate every 2 ticks.
    en = 1'b1; blink = 1'b1;
    repeat (24) cycle();
    blink = 1'b0;
    repeat (3) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
